// File: rtl/iob_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// iob_rr_arbiter_pkg
//   Shared encodings for the round-robin arbiter.
//   - BLOCK_* : integer codes for the grant hold policy. The top maps its
//               string BLOCK parameter onto one of these exactly once.
//   - state_t : arbiter state. IDLE means no grant is held, GRANTED means one is.
// ----------------------------------------------------------------------------
package iob_rr_arbiter_pkg;

    localparam int BLOCK_NONE    = 0;
    localparam int BLOCK_REQUEST = 1;
    localparam int BLOCK_ACK     = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

endpackage

// File: rtl/iob_priority_encoder.sv
// ----------------------------------------------------------------------------
// iob_priority_encoder
//   Combinational fixed-priority encoder.
//   Parameters:
//     WIDTH        : number of input bits (>= 2)
//     LSB_PRIORITY : "HIGH" -> lowest set index wins, "LOW" -> highest wins
//   Ports:
//     unencoded_i [WIDTH]         : input vector
//     encoded_o   [$clog2(WIDTH)] : index of the winning bit (0 when none set)
//     valid_o                     : at least one input bit is set
// ----------------------------------------------------------------------------
module iob_priority_encoder #(
    parameter int    WIDTH        = 4,
    parameter string LSB_PRIORITY = "HIGH"
) (
    input  logic [WIDTH-1:0]         unencoded_i,
    output logic [$clog2(WIDTH)-1:0] encoded_o,
    output logic                     valid_o
);

    localparam int IDX_W = $clog2(WIDTH);

    // The loop scans towards the preferred end so the last hit is the winner.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        encoded_o = '0;
        valid_o   = |unencoded_i;
        if (LSB_PRIORITY == "LOW") begin
            for (int i = 0; i < WIDTH; i++) begin
                if (unencoded_i[i]) encoded_o = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (unencoded_i[i]) encoded_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// ----------------------------------------------------------------------------
// iob_rr_arbiter
//   Round-robin arbiter sharing one resource between PORTS requesters.
//   Two priority encoders look at the masked and unmasked request vectors;
//   the masked result wins when any masked request exists, otherwise the
//   unmasked result wraps the rotation around.
//
//   Parameters:
//     PORTS        : number of requesters (>= 2)
//     BLOCK        : hold policy "NONE" | "REQUEST" | "ACKNOWLEDGE"
//     LSB_PRIORITY : "HIGH" (lowest index first) | "LOW" (highest index first)
//     TIMEOUT      : watchdog limit in cycles (2..65535), timeout build only
//   Ports:
//     clk_i           : clock, rising edge
//     rst_n_i         : synchronous active-low reset
//     req_i   [PORTS] : request vector
//     ack_i   [PORTS] : per-requester release, used only with "ACKNOWLEDGE"
//     grant_o [PORTS] : registered one-hot grant
//     grant_valid_o   : registered, a grant is held
//     grant_encoded_o : registered index of the granted port
//     timeout_o       : registered one-cycle pulse on a forced grant change
//                       (only when IOB_RR_ARBITER_TIMEOUT_EN is defined)
//
//   Optional feature macro: IOB_RR_ARBITER_TIMEOUT_EN
//     Adds a hold watchdog that forces a release after TIMEOUT cycles.
// ----------------------------------------------------------------------------
module iob_rr_arbiter
    import iob_rr_arbiter_pkg::*;
#(
    parameter int    PORTS        = 4,
    parameter string BLOCK        = "REQUEST",
    parameter string LSB_PRIORITY = "HIGH",
    parameter int    TIMEOUT      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [PORTS-1:0]         req_i,
    input  logic [PORTS-1:0]         ack_i,
    output logic [PORTS-1:0]         grant_o,
    output logic                     grant_valid_o,
    output logic [$clog2(PORTS)-1:0] grant_encoded_o
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
    ,
    output logic                     timeout_o
`endif
);

    localparam int IDX_W     = $clog2(PORTS);
    localparam int BLOCK_SEL = (BLOCK == "NONE")        ? BLOCK_NONE :
                               (BLOCK == "ACKNOWLEDGE") ? BLOCK_ACK  : BLOCK_REQUEST;
    localparam bit LSB_LOW   = (LSB_PRIORITY == "LOW");

    if (PORTS < 2) begin : g_chk_ports
        $error("iob_rr_arbiter: PORTS must be at least 2");
    end
    if (BLOCK != "NONE" && BLOCK != "REQUEST" && BLOCK != "ACKNOWLEDGE") begin : g_chk_block
        $error("iob_rr_arbiter: unknown BLOCK policy");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_chk_timeout
        $error("iob_rr_arbiter: TIMEOUT out of range");
    end

    state_t             state_q;
    logic [PORTS-1:0]   grant_q;
    logic [IDX_W-1:0]   enc_q;
    logic [PORTS-1:0]   mask_q;

    logic [PORTS-1:0]   masked_req;
    logic [IDX_W-1:0]   masked_enc;
    logic               masked_valid;
    logic [IDX_W-1:0]   unmasked_enc;
    logic               any_req;
    logic [IDX_W-1:0]   winner;
    logic [PORTS-1:0]   next_grant;
    logic [PORTS-1:0]   next_mask;
    logic               rel_normal;
    logic               rel;
    logic               do_arb;

    assign masked_req = req_i & mask_q;

    iob_priority_encoder #(
        .WIDTH        (PORTS),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_enc_masked (
        .unencoded_i (masked_req),
        .encoded_o   (masked_enc),
        .valid_o     (masked_valid)
    );

    iob_priority_encoder #(
        .WIDTH        (PORTS),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_enc_unmasked (
        .unencoded_i (req_i),
        .encoded_o   (unmasked_enc),
        .valid_o     (any_req)
    );

    // Masked requests sit "after" the last winner; with none left, wrap around.
    assign winner     = masked_valid ? masked_enc : unmasked_enc;
    assign next_grant = PORTS'(1) << winner;

    // The new winner moves to the back of the rotation.
    always_comb begin
        next_mask = '0;
        for (int i = 0; i < PORTS; i++) begin
            next_mask[i] = LSB_LOW ? (i < int'(winner)) : (i > int'(winner));
        end
    end

    always_comb begin
        rel_normal = 1'b0;
        case (BLOCK_SEL)
            BLOCK_NONE: rel_normal = 1'b1;
            BLOCK_ACK:  rel_normal = ack_i[enc_q];
            default:    rel_normal = ~req_i[enc_q];
        endcase
    end

`ifdef IOB_RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             expired;

    // Expiry only counts when the holder would not have released anyway.
    assign expired = (state_q == GRANTED) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !rel_normal;
    assign rel     = rel_normal | expired;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expired;
            // Arbitration happens in IDLE and on every new grant: both restart the count.
            if (do_arb) cnt_q <= '0;
            else        cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_o = timeout_q;
`else
    assign rel = rel_normal;
`endif

    assign do_arb = (state_q == IDLE) || rel;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            enc_q   <= '0;
            mask_q  <= '1;
        end else if (do_arb) begin
            if (any_req) begin
                state_q <= GRANTED;
                grant_q <= next_grant;
                enc_q   <= winner;
                mask_q  <= next_mask;
            end else begin
                state_q <= IDLE;
                grant_q <= '0;
            end
        end
    end

    assign grant_o         = grant_q;
    assign grant_valid_o   = (state_q == GRANTED);
    assign grant_encoded_o = enc_q;

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_iob_rr_arbiter
//   Directed bench for iob_rr_arbiter. Four instances cover the hold policies
//   and priority orders: 0 = REQUEST/HIGH, 1 = NONE/HIGH, 2 = ACKNOWLEDGE/HIGH,
//   3 = REQUEST/LOW. With IOB_RR_ARBITER_TIMEOUT_EN a fifth instance
//   (TIMEOUT=4) exercises the watchdog.
// ----------------------------------------------------------------------------
module tb_iob_rr_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] req   [4];
    logic [3:0] ack   [4];
    logic       rst_n [4];
    logic [3:0] gnt   [4];
    logic [1:0] enc   [4];
    logic       vld   [4];
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
    logic       to    [4];
    logic [3:0] req_t, ack_t, gnt_t;
    logic [1:0] enc_t;
    logic       rst_n_t, vld_t, to_t;
`endif

    int checks = 0;
    int errors = 0;

    iob_rr_arbiter #(.PORTS(4), .BLOCK("REQUEST"), .LSB_PRIORITY("HIGH")) u_req (
        .clk_i(clk), .rst_n_i(rst_n[0]), .req_i(req[0]), .ack_i(ack[0]),
        .grant_o(gnt[0]), .grant_valid_o(vld[0]), .grant_encoded_o(enc[0])
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        , .timeout_o(to[0])
`endif
    );

    iob_rr_arbiter #(.PORTS(4), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_none (
        .clk_i(clk), .rst_n_i(rst_n[1]), .req_i(req[1]), .ack_i(ack[1]),
        .grant_o(gnt[1]), .grant_valid_o(vld[1]), .grant_encoded_o(enc[1])
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        , .timeout_o(to[1])
`endif
    );

    iob_rr_arbiter #(.PORTS(4), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("HIGH")) u_ack (
        .clk_i(clk), .rst_n_i(rst_n[2]), .req_i(req[2]), .ack_i(ack[2]),
        .grant_o(gnt[2]), .grant_valid_o(vld[2]), .grant_encoded_o(enc[2])
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        , .timeout_o(to[2])
`endif
    );

    iob_rr_arbiter #(.PORTS(4), .BLOCK("REQUEST"), .LSB_PRIORITY("LOW")) u_low (
        .clk_i(clk), .rst_n_i(rst_n[3]), .req_i(req[3]), .ack_i(ack[3]),
        .grant_o(gnt[3]), .grant_valid_o(vld[3]), .grant_encoded_o(enc[3])
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        , .timeout_o(to[3])
`endif
    );

`ifdef IOB_RR_ARBITER_TIMEOUT_EN
    iob_rr_arbiter #(.PORTS(4), .BLOCK("REQUEST"), .LSB_PRIORITY("HIGH"), .TIMEOUT(4)) u_to (
        .clk_i(clk), .rst_n_i(rst_n_t), .req_i(req_t), .ack_i(ack_t),
        .grant_o(gnt_t), .grant_valid_o(vld_t), .grant_encoded_o(enc_t),
        .timeout_o(to_t)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Grant, encoded index and valid of instance u in one go.
    task automatic check_grant(input string tag, input int u, input logic [3:0] eg,
                               input logic [1:0] ee, input logic ev);
        check({tag, "_grant"}, 32'(gnt[u]), 32'(eg));
        check({tag, "_enc"},   32'(enc[u]), 32'(ee));
        check({tag, "_valid"}, 32'(vld[u]), 32'(ev));
    endtask

    task automatic check_idle(input string tag, input int u);
        check({tag, "_grant"}, 32'(gnt[u]), 32'h0);
        check({tag, "_valid"}, 32'(vld[u]), 32'h0);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            req[i]   = '0;
            ack[i]   = '0;
            rst_n[i] = 1'b0;
        end
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        req_t = '0; ack_t = '0; rst_n_t = 1'b0;
`endif
        step();
        step();
        for (int i = 0; i < 4; i++) check_grant($sformatf("reset%0d", i), i, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        check("reset_timeout", 32'(to_t), 32'h0);
        rst_n_t = 1'b1;
`endif
        step();

        // REQUEST, lowest index first.
        req[0] = 4'b0101; step(); check_grant("req_first", 0, 4'b0001, 2'd0, 1'b1);
        step();               check_grant("req_hold",  0, 4'b0001, 2'd0, 1'b1);
        req[0] = 4'b0100; step(); check_grant("req_next",  0, 4'b0100, 2'd2, 1'b1);
        req[0] = 4'b0010; step(); check_grant("req_wrap",  0, 4'b0010, 2'd1, 1'b1);
        req[0] = 4'b0011; step(); check_grant("req_hold1", 0, 4'b0010, 2'd1, 1'b1);
        req[0] = 4'b0001; step(); check_grant("req_to0",   0, 4'b0001, 2'd0, 1'b1);
        req[0] = 4'b0000; step(); check_idle("req_idle", 0);

        // Reset in the middle of a grant, then the mask must be back to all-ones.
        req[0] = 4'b0100; step(); check_grant("rm_g2", 0, 4'b0100, 2'd2, 1'b1);
        rst_n[0] = 1'b0; req[0] = 4'b1111; step(); check_grant("rm_rst", 0, 4'b0000, 2'd0, 1'b0);
        rst_n[0] = 1'b1; step(); check_grant("rm_after", 0, 4'b0001, 2'd0, 1'b1);

        // NONE: full rotation one grant per cycle, then a sole requester.
        req[1] = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            check_grant($sformatf("none_rr%0d", k), 1, 4'b0001 << (k % 4), 2'(k % 4), 1'b1);
        end
        req[1] = 4'b0100; step(); check_grant("none_sole_a", 1, 4'b0100, 2'd2, 1'b1);
        step();               check_grant("none_sole_b", 1, 4'b0100, 2'd2, 1'b1);
        req[1] = 4'b0000; step(); check_idle("none_idle", 1);

        // ACKNOWLEDGE: hold through withdrawal, release only on own ack.
        req[2] = 4'b0010; step(); check_grant("ack_g1", 2, 4'b0010, 2'd1, 1'b1);
        req[2] = 4'b0000; ack[2] = 4'b0000; step(); check_grant("ack_hold_a", 2, 4'b0010, 2'd1, 1'b1);
        step();                                     check_grant("ack_hold_b", 2, 4'b0010, 2'd1, 1'b1);
        req[2] = 4'b1000; ack[2] = 4'b0010; step(); check_grant("ack_g3", 2, 4'b1000, 2'd3, 1'b1);
        ack[2] = 4'b0001; step();                   check_grant("ack_ignore", 2, 4'b1000, 2'd3, 1'b1);
        req[2] = 4'b0000; ack[2] = 4'b0000; step(); check_grant("ack_hold_c", 2, 4'b1000, 2'd3, 1'b1);
        ack[2] = 4'b1000; step();                   check_idle("ack_idle", 2);
        ack[2] = 4'b0000;

        // LSB_PRIORITY="LOW": highest index first, rotation downwards.
        req[3] = 4'b0110; step(); check_grant("low_g2",   3, 4'b0100, 2'd2, 1'b1);
        req[3] = 4'b0010; step(); check_grant("low_g1",   3, 4'b0010, 2'd1, 1'b1);
        req[3] = 4'b0110; step(); check_grant("low_hold", 3, 4'b0010, 2'd1, 1'b1);
        req[3] = 4'b0100; step(); check_grant("low_wrap", 3, 4'b0100, 2'd2, 1'b1);
        req[3] = 4'b1001; step(); check_grant("low_rot",  3, 4'b0001, 2'd0, 1'b1);

`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        // Watchdog: port 0 keeps requesting, forced handover after 4 cycles.
        req_t = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("to_hold%0d", k), 32'(gnt_t), 32'h1);
            check($sformatf("to_pulse%0d", k), 32'(to_t), 32'h0);
        end
        step();
        check("to_switch", 32'(gnt_t), 32'h2);
        check("to_pulse",  32'(to_t),  32'h1);
        step();
        check("to_after",       32'(gnt_t), 32'h2);
        check("to_pulse_clear", 32'(to_t),  32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_rr_arbiter.md
Name: iob_rr_arbiter

Overview:
- Round-robin arbiter sharing one resource (bus master port, memory port) between PORTS requesters.
- Built on two iob_priority_encoder instances: masked and unmasked request vectors.
- Registered one-hot and encoded grant with selectable hold policy.
- Sits in front of bus muxes and interconnects in the buses library.

Parameters:
- PORTS, 4, number of requesters; must be at least 2.
- BLOCK, "REQUEST", grant hold policy: "NONE", "REQUEST" or "ACKNOWLEDGE".
- LSB_PRIORITY, "HIGH", fixed-priority tie order before rotation. "HIGH" means the lowest index wins; "LOW" means the highest index wins.
- TIMEOUT, 16, watchdog cycle limit. Range 2..65535. Used only with the optional feature.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- req_i  input  PORTS  request vector, one bit per requester.
- ack_i  input  PORTS  per-requester release; sampled only when BLOCK="ACKNOWLEDGE".
- grant_o  output  PORTS  one-hot grant, registered.
- grant_valid_o  output  1  a grant is held, registered.
- grant_encoded_o  output  $clog2(PORTS)  index of the granted port, registered.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk_i, rst_n_i).
- Reset (rst_n_i=0 at a clk_i edge):
  - grant_o=0, grant_valid_o=0, grant_encoded_o=0.
  - Rotation mask cleared to all-ones, so the next arbitration is pure fixed priority.
  - Reset asserted mid-grant drops the grant on that edge.
- States:
  - IDLE: grant_valid_o=0.
  - GRANTED: grant_valid_o=1, grant_o=1<<grant_encoded_o.
- IDLE -> GRANTED when |req_i=1. Grant visible the cycle after the request: latency 1.
- GRANTED release condition for granted port g:
  - "NONE": always; re-arbitrate every cycle.
  - "REQUEST": req_i[g]=0.
  - "ACKNOWLEDGE": ack_i[g]=1.
  - ack_i on non-granted ports is ignored.
- On a release cycle, arbitration among the current req_i happens in the same cycle.
  - If any request remains, go GRANTED with the new winner: back-to-back grants, no idle bubble.
  - Otherwise go IDLE.
- Rotation:
  - After granting g with LSB_PRIORITY="HIGH", mask = indices > g.
  - After granting g with LSB_PRIORITY="LOW", mask = indices < g.
  - If req_i&mask is nonzero, the masked encoder result wins; otherwise the unmasked result (wrap-around).
  - The mask updates only when a new grant is issued.
- Sole requester: the same port may be re-granted immediately after release.
- Withdrawal without release under "ACKNOWLEDGE" (req_i[g] falls while ack_i[g]=0): the grant is held until ack.
- Outputs are never combinationally dependent on inputs.

Optional Feature:
- Macro: IOB_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - Adds a $clog2(TIMEOUT+1)-bit counter, cleared on each new grant and in IDLE, incremented in GRANTED.
  - When the count reaches TIMEOUT-1 without release, the next edge forces a release and a re-arbitration.
  - The timed-out port is placed last in rotation.
  - Adds output timeout_o (1 bit): a registered one-cycle pulse coincident with the forced grant change. Reset value 0.
- Undefined: no counter, no timeout_o; grants are held indefinitely per BLOCK.

Decomposition:
- Package iob_rr_arbiter_pkg holds:
  - localparam encodings BLOCK_NONE=0, BLOCK_REQUEST=1, BLOCK_ACK=2 (string parameter mapped once);
  - state encodings IDLE=1'b0, GRANTED=1'b1.
- Sub-module: reuse iob_priority_encoder (WIDTH=PORTS, LSB_PRIORITY passthrough), instantiated twice.
- No new sub-module; mask generation and grant registers stay in this block.

Test Plan:
- PORTS=4, BLOCK="REQUEST": req_i=4'b0101 from reset -> next cycle grant_o=0001, encoded=0. Drop req[0] -> next cycle grant_o=0100, encoded=2 (no bubble).
- Round-robin fairness: req_i=4'b1111 held, BLOCK="NONE" -> grants cycle 0,1,2,3,0,1 on consecutive cycles, one grant per cycle.
- BLOCK="ACKNOWLEDGE": grant port 1, drop req[1] with ack=0 -> grant held. ack_i=4'b0010 with req=4'b1000 -> next cycle grant_o=1000. ack_i=4'b0001 while port 3 is granted -> ignored.
- Reset mid-grant: grant port 2, pull rst_n_i low for 1 edge with req=1111 -> outputs 0 that edge. After release -> grant port 0 (mask cleared).
- LSB_PRIORITY="LOW": req=4'b0110 from reset -> grant 2. Drop req[2] -> grant 1. Reassert req[2] while 1 is held, then drop req[1] -> grant 2 (wrap).
- With IOB_RR_ARBITER_TIMEOUT_EN, TIMEOUT=4: port 0 holds req, req=0011 -> grant 0 for 4 cycles, then grant 1 with timeout_o=1 for one cycle.
